// File: rtl/ov7670_sccb_init_sequencer.sv
// OV7670 power-up and register-table sequencer driving an SCCB/i2c master over AXI-stream.
// Latency: RST_CYCLES + BOOT_CYCLES before the first command; 2 cycles of fetch/decode per table entry.
// Backpressure: cmd/data valids and payloads are held until their ready is seen; read data is drained.
//
// Ports:
//   clk, reset_ (async active-low), start (pulse: begin/restart when not busy)
//   rom_addr/rom_data     : table index out, {reg_addr, value} back one cycle later
//   cam_rst_n, cam_pwdn   : camera reset (low = reset) and power-down (high = off)
//   s_axis_cmd_*          : i2c master command channel (address always CAM_ADDR)
//   s_axis_data_*         : write data to the i2c master, tlast on the final byte of a write
//   m_axis_data_*         : read data from the i2c master
//   busy, done, error     : status; regs_written counts completed writes (saturating)
// Build option: define OV7670_SCCB_READBACK_EN to read back and compare every written register.
module ov7670_sccb_init_sequencer #(
  parameter logic [6:0] CAM_ADDR    = 7'h21,
  parameter int         ROM_AW      = 6,
  parameter int         RST_CYCLES  = 100000,
  parameter int         BOOT_CYCLES = 100000,
  parameter int         DELAY_UNIT  = 100000
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              cam_rst_n,
  output logic              cam_pwdn,
  output logic [6:0]        s_axis_cmd_address,
  output logic              s_axis_cmd_start,
  output logic              s_axis_cmd_read,
  output logic              s_axis_cmd_write,
  output logic              s_axis_cmd_write_multiple,
  output logic              s_axis_cmd_stop,
  output logic              s_axis_cmd_valid,
  input  logic              s_axis_cmd_ready,
  output logic [7:0]        s_axis_data_tdata,
  output logic              s_axis_data_tvalid,
  output logic              s_axis_data_tlast,
  input  logic              s_axis_data_tready,
  input  logic [7:0]        m_axis_data_tdata,
  input  logic              m_axis_data_tvalid,
  input  logic              m_axis_data_tlast,
  output logic              m_axis_data_tready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        regs_written
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PWR,
    S_BOOT,
    S_FETCH,
    S_DECODE,
    S_CMD,
    S_DATA0,
    S_DATA1,
`ifdef OV7670_SCCB_READBACK_EN
    S_VCMD,
    S_VDATA,
    S_VRCMD,
    S_VRD,
`endif
    S_DELAY,
    S_DONE
  } state_t;

  localparam logic [ROM_AW-1:0] ADDR_ONE  = 1;
  localparam logic [ROM_AW-1:0] ADDR_LAST = '1;

`ifdef OV7670_SCCB_READBACK_EN
  // Read data is only accepted while a readback is outstanding.
  localparam logic MT_RDY_IDLE = 1'b0;
`else
  // Nothing is ever read, so anything the master returns is simply drained.
  localparam logic MT_RDY_IDLE = 1'b1;
`endif

  state_t      state;
  logic [31:0] cnt;
  logic [7:0]  reg_q;
  logic [7:0]  val_q;

  assign s_axis_cmd_address = CAM_ADDR;

  // Read-channel inputs that this build never looks at.
  logic unused_rd;
  assign unused_rd = ^{m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast};

  always_ff @(posedge clk or negedge reset_) begin : seq
    logic adv;  // current entry finished: step to the next one or stop at table end
    if (!reset_) begin
      state                     <= S_IDLE;
      cnt                       <= '0;
      rom_addr                  <= '0;
      reg_q                     <= '0;
      val_q                     <= '0;
      cam_rst_n                 <= 1'b0;
      cam_pwdn                  <= 1'b1;
      s_axis_cmd_start          <= 1'b0;
      s_axis_cmd_read           <= 1'b0;
      s_axis_cmd_write          <= 1'b0;
      s_axis_cmd_write_multiple <= 1'b0;
      s_axis_cmd_stop           <= 1'b0;
      s_axis_cmd_valid          <= 1'b0;
      s_axis_data_tdata         <= '0;
      s_axis_data_tvalid        <= 1'b0;
      s_axis_data_tlast         <= 1'b0;
      m_axis_data_tready        <= 1'b1;
      busy                      <= 1'b0;
      done                      <= 1'b0;
      error                     <= 1'b0;
      regs_written              <= '0;
    end else begin
      adv = 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_PWR;
            cnt          <= 32'(RST_CYCLES - 1);
            rom_addr     <= '0;
            cam_pwdn     <= 1'b0;
            cam_rst_n    <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            regs_written <= '0;
            m_axis_data_tready <= MT_RDY_IDLE;
          end
        end
        S_PWR: begin
          if (cnt == '0) begin
            state     <= S_BOOT;
            cam_rst_n <= 1'b1;
            cnt       <= 32'(BOOT_CYCLES - 1);
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        S_BOOT: begin
          if (cnt == '0) state <= S_FETCH;
          else           cnt   <= cnt - 32'd1;
        end
        // rom_addr is already on the bus; give the table one cycle to answer.
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          reg_q <= rom_data[15:8];
          val_q <= rom_data[7:0];
          if (rom_data == 16'hFFFF) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (rom_data[15:8] == 8'hFF) begin
            if (rom_data[7:0] == 8'h00) begin
              adv = 1'b1;
            end else begin
              state <= S_DELAY;
              cnt   <= 32'(rom_data[7:0]) * 32'(DELAY_UNIT) - 32'd1;
            end
          end else begin
            state                     <= S_CMD;
            s_axis_cmd_valid          <= 1'b1;
            s_axis_cmd_start          <= 1'b1;
            s_axis_cmd_read           <= 1'b0;
            s_axis_cmd_write          <= 1'b0;
            s_axis_cmd_write_multiple <= 1'b1;
            s_axis_cmd_stop           <= 1'b1;
          end
        end
        S_DELAY: begin
          if (cnt == '0) adv = 1'b1;
          else           cnt <= cnt - 32'd1;
        end
        S_CMD: begin
          if (s_axis_cmd_ready) begin
            state              <= S_DATA0;
            s_axis_cmd_valid   <= 1'b0;
            s_axis_data_tdata  <= reg_q;
            s_axis_data_tlast  <= 1'b0;
            s_axis_data_tvalid <= 1'b1;
          end
        end
        S_DATA0: begin
          if (s_axis_data_tready) begin
            state             <= S_DATA1;
            s_axis_data_tdata <= val_q;
            s_axis_data_tlast <= 1'b1;
          end
        end
        S_DATA1: begin
          if (s_axis_data_tready) begin
            s_axis_data_tvalid <= 1'b0;
            s_axis_data_tlast  <= 1'b0;
            if (regs_written != 8'hFF) regs_written <= regs_written + 8'd1;
`ifdef OV7670_SCCB_READBACK_EN
            // COM7 soft reset wipes the register file, so reading it back is meaningless.
            if (reg_q == 8'h12 && val_q[7]) begin
              adv = 1'b1;
            end else begin
              state                     <= S_VCMD;
              s_axis_cmd_valid          <= 1'b1;
              s_axis_cmd_start          <= 1'b1;
              s_axis_cmd_read           <= 1'b0;
              s_axis_cmd_write          <= 1'b1;
              s_axis_cmd_write_multiple <= 1'b0;
              s_axis_cmd_stop           <= 1'b1;
            end
`else
            adv = 1'b1;
`endif
          end
        end
`ifdef OV7670_SCCB_READBACK_EN
        S_VCMD: begin
          if (s_axis_cmd_ready) begin
            state              <= S_VDATA;
            s_axis_cmd_valid   <= 1'b0;
            s_axis_data_tdata  <= reg_q;
            s_axis_data_tlast  <= 1'b1;
            s_axis_data_tvalid <= 1'b1;
          end
        end
        S_VDATA: begin
          if (s_axis_data_tready) begin
            state              <= S_VRCMD;
            s_axis_data_tvalid <= 1'b0;
            s_axis_data_tlast  <= 1'b0;
            s_axis_cmd_valid   <= 1'b1;
            s_axis_cmd_start   <= 1'b1;
            s_axis_cmd_read    <= 1'b1;
            s_axis_cmd_write   <= 1'b0;
            s_axis_cmd_write_multiple <= 1'b0;
            s_axis_cmd_stop    <= 1'b1;
          end
        end
        S_VRCMD: begin
          if (s_axis_cmd_ready) begin
            state              <= S_VRD;
            s_axis_cmd_valid   <= 1'b0;
            m_axis_data_tready <= 1'b1;
          end
        end
        S_VRD: begin
          if (m_axis_data_tvalid) begin
            m_axis_data_tready <= 1'b0;
            // A mismatch is recorded but the remaining table is still written.
            if (m_axis_data_tdata != val_q) error <= 1'b1;
            adv = 1'b1;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase

      if (adv) begin
        if (rom_addr == ADDR_LAST) begin
          // Ran off the end of the table without an end marker.
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          error <= 1'b1;
        end else begin
          state    <= S_FETCH;
          rom_addr <= rom_addr + ADDR_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_sccb_init_sequencer.sv
// Bench for ov7670_sccb_init_sequencer: 4-entry table, short power-up and delay timings.
// Write bytes are checked against a queue built from the loaded table; status via vectors.
// Multi-cycle cases (power-up timing, cmd stall, delay gap, reset mid-write) are sequences.
module tb_ov7670_sccb_init_sequencer;

  localparam int RST_C  = 4;
  localparam int BOOT_C = 4;
  localparam int DU     = 5;

  logic        clk = 1'b0;
  logic        reset_;
  logic        start;
  logic [1:0]  rom_addr;
  logic [15:0] rom_data;
  logic        cam_rst_n, cam_pwdn;
  logic [6:0]  s_axis_cmd_address;
  logic        s_axis_cmd_start, s_axis_cmd_read, s_axis_cmd_write;
  logic        s_axis_cmd_write_multiple, s_axis_cmd_stop;
  logic        s_axis_cmd_valid, s_axis_cmd_ready;
  logic [7:0]  s_axis_data_tdata;
  logic        s_axis_data_tvalid, s_axis_data_tlast, s_axis_data_tready;
  logic [7:0]  m_axis_data_tdata;
  logic        m_axis_data_tvalid, m_axis_data_tlast, m_axis_data_tready;
  logic        busy, done, error;
  logic [7:0]  regs_written;

  always #5 clk = ~clk;

  ov7670_sccb_init_sequencer #(
    .CAM_ADDR(7'h21), .ROM_AW(2), .RST_CYCLES(RST_C), .BOOT_CYCLES(BOOT_C), .DELAY_UNIT(DU)
  ) dut (
    .clk(clk), .reset_(reset_), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .cam_rst_n(cam_rst_n), .cam_pwdn(cam_pwdn),
    .s_axis_cmd_address(s_axis_cmd_address),
    .s_axis_cmd_start(s_axis_cmd_start), .s_axis_cmd_read(s_axis_cmd_read),
    .s_axis_cmd_write(s_axis_cmd_write), .s_axis_cmd_write_multiple(s_axis_cmd_write_multiple),
    .s_axis_cmd_stop(s_axis_cmd_stop), .s_axis_cmd_valid(s_axis_cmd_valid),
    .s_axis_cmd_ready(s_axis_cmd_ready),
    .s_axis_data_tdata(s_axis_data_tdata), .s_axis_data_tvalid(s_axis_data_tvalid),
    .s_axis_data_tlast(s_axis_data_tlast), .s_axis_data_tready(s_axis_data_tready),
    .m_axis_data_tdata(m_axis_data_tdata), .m_axis_data_tvalid(m_axis_data_tvalid),
    .m_axis_data_tlast(m_axis_data_tlast), .m_axis_data_tready(m_axis_data_tready),
    .busy(busy), .done(done), .error(error), .regs_written(regs_written)
  );

  // Register table: synchronous read, data one cycle after the address.
  logic [15:0] rom [4];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: {tlast, byte} per expected data beat.
  logic [8:0] exp_q [$];
  int         gaps [$];
  int         cyc = 0;
  int         last_tl = 0;
  bit         want_gap = 0;
  int         cmd_accepts = 0;
  bit         rand_rdy = 0;

  task automatic push_expect();
    for (int i = 0; i < 4; i++) begin
      if (rom[i] == 16'hFFFF) break;
      if (rom[i][15:8] != 8'hFF) begin
        exp_q.push_back({1'b0, rom[i][15:8]});
        exp_q.push_back({1'b1, rom[i][7:0]});
      end
    end
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic [15:0] d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    exp_q.delete();
    gaps.delete();
    want_gap = 0;
    push_expect();
  endtask

  // Sampled 1 time unit after the falling edge: inputs are settled and hold until the rising edge.
  always @(negedge clk) begin
    #1;
    cyc++;
    if (reset_) begin
      if (s_axis_data_tvalid && s_axis_data_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra_byte: got %0h with no byte expected", s_axis_data_tdata);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("sb_byte", {23'd0, s_axis_data_tlast, s_axis_data_tdata}, {23'd0, e});
        end
        if (s_axis_data_tlast) begin
          last_tl  = cyc;
          want_gap = 1;
        end
      end
      if (want_gap && s_axis_cmd_valid) begin
        gaps.push_back(cyc - last_tl);
        want_gap = 0;
      end
      if (s_axis_cmd_valid && s_axis_cmd_ready) cmd_accepts++;
    end
  end

  // Random data-channel backpressure, changed just after the rising edge.
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      s_axis_data_tready = 1'($urandom_range(0, 1));
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, 32'(done), 32'd1);
  endtask

  typedef struct {
    logic [15:0] t0, t1, t2, t3;
    int          writes;
    bit          err;
  } vec_t;
  vec_t vecs [7];

  task automatic set_vec(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d, input int w, input bit e);
    vecs[i].t0 = a; vecs[i].t1 = b; vecs[i].t2 = c; vecs[i].t3 = d;
    vecs[i].writes = w;
    vecs[i].err = e;
  endtask

  initial begin
    int low, high, act, unstable, n;
    logic [11:0] flags0;

    set_vec(0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0);  // immediate end
    set_vec(1, 16'h1280, 16'h1100, 16'hFFFF, 16'h0000, 2, 1'b0);
    set_vec(2, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 4, 1'b1);  // no end marker
    set_vec(3, 16'hFF00, 16'h1280, 16'hFFFF, 16'h0000, 1, 1'b0);  // zero delay
    set_vec(4, 16'h1280, 16'hFF01, 16'h1100, 16'hFFFF, 2, 1'b0);
    set_vec(5, 16'h1201, 16'h1302, 16'h1403, 16'hFFFF, 3, 1'b0);  // end in last slot
    set_vec(6, 16'h1280, 16'h1100, 16'h1200, 16'hFF01, 3, 1'b1);  // delay in last slot

    reset_ = 1'b0;
    start = 1'b0;
    s_axis_cmd_ready = 1'b1;
    s_axis_data_tready = 1'b1;
    m_axis_data_tdata = 8'h00;
    m_axis_data_tvalid = 1'b0;
    m_axis_data_tlast = 1'b0;
    rom[0] = 16'hFFFF; rom[1] = 16'hFFFF; rom[2] = 16'hFFFF; rom[3] = 16'hFFFF;
    repeat (3) @(negedge clk);

    chk("rst_pwdn",  32'(cam_pwdn), 32'd1);
    chk("rst_rst_n", 32'(cam_rst_n), 32'd0);
    chk("rst_status", {29'd0, busy, done, error}, 32'd0);
    chk("rst_regs", 32'(regs_written), 32'd0);
    chk("rst_valids", {30'd0, s_axis_cmd_valid, s_axis_data_tvalid}, 32'd0);
    chk("rst_mtready", 32'(m_axis_data_tready), 32'd1);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("cmd_address", 32'(s_axis_cmd_address), 32'h21);

    // Power-up timing; a second start during PWR must be ignored.
    reset_ = 1'b1;
    @(negedge clk);
    load(16'h1280, 16'h1100, 16'hFFFF, 16'h0000);
    low = 0; high = 0; act = 0;
    start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start = (i == 1);
      if (s_axis_cmd_valid) break;
      if (s_axis_data_tvalid) act++;
      if (!cam_rst_n && !cam_pwdn) low++;
      if (cam_rst_n) high++;
    end
    start = 1'b0;
    chk("pwr_first_cmd", 32'(s_axis_cmd_valid), 32'd1);
    chk("pwr_rst_low", 32'(low), 32'(RST_C));
    // rst_n high through BOOT, then one FETCH and one DECODE cycle before the command.
    chk("pwr_rst_high", 32'(high), 32'(BOOT_C + 2));
    chk("pwr_no_data", 32'(act), 32'd0);
    chk("pwr_busy", 32'(busy), 32'd1);
    wait_done("t1");
    chk("t1_regs", 32'(regs_written), 32'd2);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t1_gap_cnt", 32'(gaps.size()), 32'd1);
    // After a write: FETCH, DECODE, then the next cmd_valid on the third cycle.
    if (gaps.size() == 1) chk("t1_gap", 32'(gaps[0]), 32'd3);

    // Command stall: valid and flags frozen while ready is low, single accept after.
    load(16'h1280, 16'h1100, 16'hFFFF, 16'h0000);
    s_axis_cmd_ready = 1'b0;
    cmd_accepts = 0;
    pulse_start();
    n = 0;
    while (!s_axis_cmd_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid", 32'(s_axis_cmd_valid), 32'd1);
    flags0 = {s_axis_cmd_address, s_axis_cmd_start, s_axis_cmd_read, s_axis_cmd_write,
              s_axis_cmd_write_multiple, s_axis_cmd_stop};
    chk("cmd_flags", 32'(flags0), {20'd0, 7'h21, 5'b10011});
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!s_axis_cmd_valid ||
          {s_axis_cmd_address, s_axis_cmd_start, s_axis_cmd_read, s_axis_cmd_write,
           s_axis_cmd_write_multiple, s_axis_cmd_stop} !== flags0) unstable++;
    end
    chk("stall_hold", 32'(unstable), 32'd0);
    chk("stall_no_accept", 32'(cmd_accepts), 32'd0);
    s_axis_cmd_ready = 1'b1;
    wait_done("stall");
    chk("stall_accepts", 32'(cmd_accepts), 32'd2);
    chk("stall_regs", 32'(regs_written), 32'd2);

    // Delay entry FF03 with DELAY_UNIT=5: 15 wait cycles plus the delay entry's own fetch/decode.
    load(16'h1280, 16'hFF03, 16'h1100, 16'hFFFF);
    pulse_start();
    wait_done("delay");
    chk("delay_regs", 32'(regs_written), 32'd2);
    chk("delay_gap_cnt", 32'(gaps.size()), 32'd1);
    if (gaps.size() == 1) chk("delay_gap", 32'(gaps[0]), 32'(3 + 2 + 3 * DU));

    // Table vectors under random data backpressure.
    rand_rdy = 1;
    for (int v = 0; v < 7; v++) begin
      load(vecs[v].t0, vecs[v].t1, vecs[v].t2, vecs[v].t3);
      pulse_start();
      wait_done($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
      chk($sformatf("vec%0d_error", v), 32'(error), 32'(vecs[v].err));
      chk($sformatf("vec%0d_regs", v), 32'(regs_written), 32'(vecs[v].writes));
      chk($sformatf("vec%0d_sb_empty", v), 32'(exp_q.size()), 32'd0);
      chk($sformatf("vec%0d_cam", v), {30'd0, cam_pwdn, cam_rst_n}, 32'd1);
    end
    rand_rdy = 0;
    @(negedge clk);
    s_axis_data_tready = 1'b1;

    // Reset while the second entry's register byte is on the bus.
    load(16'h1280, 16'h1100, 16'hFFFF, 16'h0000);
    pulse_start();
    n = 0;
    while (!(s_axis_data_tvalid && !s_axis_data_tlast && rom_addr == 2'd1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached_data0", 32'(s_axis_data_tvalid), 32'd1);
    reset_ = 1'b0;
    #1;
    chk("mid_rst_cam", {30'd0, cam_pwdn, cam_rst_n}, 32'd2);
    chk("mid_rst_valids", {30'd0, s_axis_cmd_valid, s_axis_data_tvalid}, 32'd0);
    chk("mid_rst_status", {29'd0, busy, done, error}, 32'd0);
    chk("mid_rst_regs", 32'(regs_written), 32'd0);
    chk("mid_rst_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    reset_ = 1'b1;
    load(16'h1280, 16'h1100, 16'hFFFF, 16'h0000);
    @(negedge clk);
    pulse_start();
    wait_done("restart");
    chk("restart_regs", 32'(regs_written), 32'd2);
    chk("restart_sb_empty", 32'(exp_q.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
